// File: rtl/fib_fsm.sv
// -----------------------------------------------------------------------------
// fib_fsm
//
// Hard-wired control sequencer that steers a 16-bit register-file/ALU datapath
// through the Fibonacci sequence, leaving r0..r15 = 0,1,1,2,3,...,610.
// The block holds no datapath of its own. It only emits one control word per
// clock, as a pure (Moore) decode of the current state.
//
// Ports
//   clk      in   1   system clock, state advances on the rising edge
//   reset    in   1   asynchronous, active-low; low forces state S0 at once
//   alu_op   out  8   ALU opcode (00 NOP, 01 ADD, 82 MOVI; bit 7 = B from imm)
//   muxes    out  8   [7:4] register index for ALU A, [3:0] index for ALU B
//   regs_en  out  16  one-hot register write enables (bit k writes rk)
//   imm      out  16  immediate presented to the datapath
// -----------------------------------------------------------------------------
module fib_fsm (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  alu_op,
  output logic [7:0]  muxes,
  output logic [15:0] regs_en,
  output logic [15:0] imm
);

  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_MOVI = 8'h82;

  // S0..S15 are numbered so that the low nibble is the destination register
  // index; DONE sits alone in the upper half of the 5-bit space, as do all
  // unused encodings.
  typedef enum logic [4:0] {
    S0   = 5'd0,
    S1   = 5'd1,
    S2   = 5'd2,
    S3   = 5'd3,
    S4   = 5'd4,
    S5   = 5'd5,
    S6   = 5'd6,
    S7   = 5'd7,
    S8   = 5'd8,
    S9   = 5'd9,
    S10  = 5'd10,
    S11  = 5'd11,
    S12  = 5'd12,
    S13  = 5'd13,
    S14  = 5'd14,
    S15  = 5'd15,
    DONE = 5'd16
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  state_bits;
  logic        in_seq;
  logic [3:0]  step;
  logic [3:0]  step_m1;
  logic [3:0]  step_m2;

  // State register: reset acts immediately, so outputs follow reset without
  // waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_bits = state_q;
  assign in_seq     = ~state_bits[4];
  assign step       = state_bits[3:0];
  assign step_m1    = step - 4'd1;
  assign step_m2    = step - 4'd2;

  // Next state: walk S0..S15 in order, then park in DONE. DONE and every
  // unused encoding fall through to DONE.
  always_comb begin
    state_d = DONE;
    if (in_seq && (state_q != S15)) begin
      state_d = state_t'(state_bits + 5'd1);
    end
  end

  // Output decode. S0/S1 seed r0/r1 with immediates; every later state adds
  // the two preceding registers into the register named by the state index.
  always_comb begin
    alu_op  = ALU_NOP;
    muxes   = 8'h00;
    regs_en = 16'h0000;
    imm     = 16'h0000;
    if (in_seq) begin
      regs_en = 16'h0001 << step;
      case (step)
        4'd0: begin
          alu_op = ALU_MOVI;
          imm    = 16'h0000;
        end
        4'd1: begin
          alu_op = ALU_MOVI;
          imm    = 16'h0001;
        end
        default: begin
          alu_op = ALU_ADD;
          muxes  = {step_m2, step_m1};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_fsm.sv
module tb_fib_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  alu_op;
  logic [7:0]  muxes;
  logic [15:0] regs_en;
  logic [15:0] imm;

  int tests = 0;
  int fails = 0;

  fib_fsm dut (
    .clk     (clk),
    .reset   (reset),
    .alu_op  (alu_op),
    .muxes   (muxes),
    .regs_en (regs_en),
    .imm     (imm)
  );

  always #5 clk = ~clk;

  // Expected control word {alu_op, muxes, regs_en, imm} after n rising edges
  // since reset release.
  function automatic logic [47:0] model(input int n);
    logic [7:0]  op;
    logic [7:0]  mx;
    logic [15:0] en;
    logic [15:0] im;
    op = 8'h00; mx = 8'h00; en = 16'h0000; im = 16'h0000;
    if (n < 2) begin
      op = 8'h82;
      im = 16'(n);
      en = 16'(1 << n);
    end else if (n < 16) begin
      op = 8'h01;
      mx = {4'(n - 2), 4'(n - 1)};
      en = 16'(1 << n);
    end
    return {op, mx, en, im};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    #1;
    tests++;
    if ({alu_op, muxes, regs_en, imm} !== model(0)) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h", {alu_op, muxes, regs_en, imm}, model(0));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({alu_op, muxes, regs_en, imm} !== model(0)) begin
      fails++;
      $display("FAIL reset_held_edges: got %h expected %h", {alu_op, muxes, regs_en, imm}, model(0));
    end
  endtask

  // Releases reset at a falling edge and checks the full walk plus DONE hold.
  task automatic test_sequence();
    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      tests++;
      if ({alu_op, muxes, regs_en, imm} !== model(n)) begin
        fails++;
        $display("FAIL seq_edge%0d: got %h expected %h", n, {alu_op, muxes, regs_en, imm}, model(n));
      end
      tests++;
      if ($countones(regs_en) > 1) begin
        fails++;
        $display("FAIL seq_onehot%0d: got regs_en %h expected at most one bit", n, regs_en);
      end
    end
  endtask

  // Runs k edges, asserts reset between edges, then releases and runs m edges.
  task automatic test_mid_reset(input int k, input int m);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= k; n++) begin
      @(negedge clk);
      tests++;
      if ({alu_op, muxes, regs_en, imm} !== model(n)) begin
        fails++;
        $display("FAIL mid_pre_k%0d_edge%0d: got %h expected %h", k, n, {alu_op, muxes, regs_en, imm}, model(n));
      end
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if ({alu_op, muxes, regs_en, imm} !== model(0)) begin
      fails++;
      $display("FAIL mid_async_k%0d: got %h expected %h", k, {alu_op, muxes, regs_en, imm}, model(0));
    end
    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= m; n++) begin
      @(negedge clk);
      tests++;
      if ({alu_op, muxes, regs_en, imm} !== model(n)) begin
        fails++;
        $display("FAIL mid_post_k%0d_edge%0d: got %h expected %h", k, n, {alu_op, muxes, regs_en, imm}, model(n));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 6; r++) begin
      test_mid_reset(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)));
    end
  endtask

  // Drives a behavioural register file/ALU from the control word and checks
  // the final register contents against the Fibonacci numbers.
  task automatic test_datapath();
    logic [15:0] rf  [16];
    logic [15:0] fib [16];
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] en;
    fib[0] = 16'd0;
    fib[1] = 16'd1;
    for (int i = 2; i < 16; i++) fib[i] = fib[i-2] + fib[i-1];
    for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int e = 0; e < 20; e++) begin
      a   = rf[muxes[7:4]];
      b   = alu_op[7] ? imm : rf[muxes[3:0]];
      res = 16'h0000;
      if (alu_op == 8'h01) res = a + b;
      else if (alu_op == 8'h82) res = imm;
      en = regs_en;
      @(posedge clk);
      for (int i = 0; i < 16; i++) if (en[i]) rf[i] = res;
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (rf[i] !== fib[i]) begin
        fails++;
        $display("FAIL datapath_r%0d: got %0d expected %0d", i, rf[i], fib[i]);
      end
    end
    tests++;
    if (rf[15] !== 16'h0262) begin
      fails++;
      $display("FAIL datapath_r15_hex: got %h expected 0262", rf[15]);
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_sequence();
    test_mid_reset(7, 2);
    test_back_to_back();
    test_datapath();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
